// File: rtl/datamover_engine_pkg.sv
// Shared types for the datamover stream engine: FSM encoding and the
// controller-facing control/flag records.
package datamover_package;

  localparam int unsigned ENG_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } engine_state_e;

  typedef struct packed {
    logic                 start;
    logic [ENG_CNT_W-1:0] len;
  } ctrl_engine_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [ENG_CNT_W-1:0] beat_cnt;
  } flags_engine_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE-Stream handshake bundle: valid/ready with data and byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/datamover_engine_fifo.sv
// Small data+strobe FIFO with async active-high reset and sync clear.
// Head word reads as zero while empty so the stream output idles clean.
module datamover_engine_fifo #(
  parameter int unsigned BW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [BW+BW/8-1:0]   push_data_i,
  input  logic                 pop_i,
  output logic [BW+BW/8-1:0]   pop_data_o,
  output logic                 full_o,
  output logic                 empty_o
);
  localparam int unsigned W  = BW + BW / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          push_ok, pop_ok;

  assign full_o  = (occ == FULL_OCC);
  assign empty_o = (occ == '0);
  // No full-bypass: a push while full is dropped even if a pop coincides.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign pop_data_o = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/datamover_engine.sv
// Stream engine between the datamover load and store paths: accepts exactly
// len beats, buffers them and forwards them unchanged, reporting progress.
module datamover_engine
  import datamover_package::*;
#(
  parameter int unsigned BW        = 32,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  hwpe_stream_intf_stream.sink   data_in,
  hwpe_stream_intf_stream.source data_out,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] beat_cnt_o
);
  engine_state_e    state;
  logic [CNT_W-1:0] len_q, in_cnt, out_cnt;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  assign data_in.ready  = (state == RUN) & enable_i & ~fifo_full & (in_cnt != len_q);
  assign data_out.valid = ~fifo_empty;
  assign push = data_in.valid & data_in.ready;
  assign pop  = data_out.valid & data_out.ready;

  assign busy_o     = (state == RUN) | (state == DRAIN);
  assign done_o     = (state == DONE);
  assign beat_cnt_o = out_cnt;

  datamover_engine_fifo #(
    .BW    (BW),
    .DEPTH (BUF_DEPTH)
  ) i_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_i      (push),
    .push_data_i ({data_in.strb, data_in.data}),
    .pop_i       (pop),
    .pop_data_o  ({data_out.strb, data_out.data}),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (clear_i) begin
      state   <= IDLE;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (push) in_cnt  <= in_cnt + CNT_W'(1);
      if (pop)  out_cnt <= out_cnt + CNT_W'(1);
      case (state)
        IDLE: if (start_i) begin
          // Counters restart per job; beat_cnt_o holds the last job's count until then.
          len_q   <= len_i;
          in_cnt  <= '0;
          out_cnt <= '0;
          state   <= (len_i != '0) ? RUN : DONE;
        end
        RUN:     if (in_cnt == len_q)  state <= DRAIN;
        DRAIN:   if (out_cnt == len_q) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamover_engine.sv
// Directed bench for datamover_engine: per-job stimulus with hand-derived
// expectations for ordering, latency, back-pressure, abort and enable gating.
module tb_datamover_engine;
  localparam int BW = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, clear, enable, start;
  logic [CNT_W-1:0] len;
  logic             busy, done;
  logic [CNT_W-1:0] beat_cnt;

  hwpe_stream_intf_stream #(.DATA_WIDTH(BW)) din ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(BW)) dout ();

  datamover_engine #(.BW(BW), .BUF_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .enable_i   (enable),
    .start_i    (start),
    .len_i      (len),
    .data_in    (din.sink),
    .data_out   (dout.source),
    .busy_o     (busy),
    .done_o     (done),
    .beat_cnt_o (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc_n = 0, acc_cnt = 0, done_cnt = 0;
  int first_acc_cyc = 0, first_out_cyc = 0, last_out_cyc = 0, done_cyc = 0;
  bit rdy_seen, vld_seen;
  int src_idx = 0, src_n = 0;
  logic [31:0] src_base = '0;
  logic [3:0]  src_strb = '0;
  logic [35:0] got_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe handshakes mid-cycle, then advance the source after the edge.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    if (din.valid && din.ready) begin
      if (acc_cnt == 0) first_acc_cyc = cyc_n;
      acc_cnt++;
      src_idx++;
    end
    if (dout.valid && dout.ready) begin
      if (got_q.size() == 0) first_out_cyc = cyc_n;
      last_out_cyc = cyc_n;
      got_q.push_back({dout.strb, dout.data});
    end
    if (done) begin done_cnt++; done_cyc = cyc_n; end
    if (din.ready) rdy_seen = 1'b1;
    if (dout.valid) vld_seen = 1'b1;
    @(posedge clk);
    #1;
    din.valid = (src_idx < src_n);
    din.data  = src_base + 32'(src_idx);
    din.strb  = src_strb;
  endtask

  task automatic new_job(input int l, input logic [31:0] base, input int n, input logic [3:0] strb);
    acc_cnt = 0; done_cnt = 0; rdy_seen = 0; vld_seen = 0;
    got_q.delete();
    src_idx = 0; src_n = n; src_base = base; src_strb = strb;
    din.valid = (n > 0); din.data = base; din.strb = strb;
    len = CNT_W'(l);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == 0 && k < 60) begin cyc(); k++; end
    chk(tag, 64'(done_cnt != 0), 64'd1);
    cyc(); cyc();
  endtask

  task automatic chk_stream(input string tag, input int n, input logic [31:0] base, input logic [3:0] strb);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({tag, "_beat"}, 64'(got_q[i]), 64'({strb, base + 32'(i)}));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; enable = 1'b1; start = 1'b0; len = '0;
    din.valid = 1'b0; din.data = '0; din.strb = '0; dout.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(din.ready), 64'd0);
    chk("rst_valid", 64'(dout.valid), 64'd0);
    chk("rst_data", 64'(dout.data), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcnt", 64'(beat_cnt), 64'd0);

    // 1: plain 5-beat job, sink always ready
    dout.ready = 1'b1;
    new_job(5, 32'h10, 5, 4'hF);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done_seen");
    chk_stream("t1", 5, 32'h10, 4'hF);
    chk("t1_latency", 64'(first_out_cyc - first_acc_cyc), 64'd1);
    chk("t1_done_once", 64'(done_cnt), 64'd1);
    chk("t1_bcnt", 64'(beat_cnt), 64'd5);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // 2: sink stalled, FIFO fills at 4 then drains
    dout.ready = 1'b0;
    new_job(8, 32'h20, 8, 4'hF);
    repeat (12) cyc();
    chk("t2_acc_full", 64'(acc_cnt), 64'd4);
    chk("t2_ready_full", 64'(din.ready), 64'd0);
    chk("t2_head", 64'(dout.data), 64'h20);
    dout.ready = 1'b1;
    wait_done("t2_done_seen");
    chk_stream("t2", 8, 32'h20, 4'hF);
    chk("t2_done_once", 64'(done_cnt), 64'd1);

    // 3: zero-length job
    new_job(0, 32'h90, 2, 4'hF);
    chk("t3_done_next", 64'(done), 64'd1);
    repeat (3) cyc();
    chk("t3_done_once", 64'(done_cnt), 64'd1);
    chk("t3_no_ready", 64'(rdy_seen), 64'd0);
    chk("t3_no_valid", 64'(vld_seen), 64'd0);

    // 4: source offers more beats than the job length
    new_job(3, 32'h30, 6, 4'hF);
    wait_done("t4_done_seen");
    chk("t4_acc", 64'(acc_cnt), 64'd3);
    chk_stream("t4", 3, 32'h30, 4'hF);
    chk("t4_extra_blocked", 64'({din.valid, din.ready}), 64'b10);
    chk("t4_done_after_out", 64'(done_cyc > last_out_cyc && done_cyc <= last_out_cyc + 3), 64'd1);

    // 5a: sync clear mid-job, then a fresh job
    new_job(6, 32'h40, 6, 4'hF);
    for (int k = 0; k < 20 && acc_cnt < 3; k++) cyc();
    chk("t5_pre_bcnt", 64'(beat_cnt), 64'd2);
    chk("t5_pre_valid", 64'(dout.valid), 64'd1);
    src_n = src_idx; din.valid = 1'b0; dout.ready = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("t5c_valid", 64'(dout.valid), 64'd0);
    chk("t5c_data", 64'(dout.data), 64'd0);
    chk("t5c_bcnt", 64'(beat_cnt), 64'd0);
    chk("t5c_busy", 64'(busy), 64'd0);
    repeat (3) cyc();
    chk("t5c_no_done", 64'(done_cnt), 64'd0);
    dout.ready = 1'b1;
    new_job(2, 32'h50, 2, 4'hF);
    wait_done("t5c_done_seen");
    chk_stream("t5c", 2, 32'h50, 4'hF);

    // 5b: async reset mid-job, then a fresh job
    new_job(6, 32'h40, 6, 4'hF);
    for (int k = 0; k < 20 && acc_cnt < 3; k++) cyc();
    src_n = src_idx; din.valid = 1'b0; dout.ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5r_valid", 64'(dout.valid), 64'd0);
    chk("t5r_bcnt", 64'(beat_cnt), 64'd0);
    chk("t5r_busy", 64'(busy), 64'd0);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();
    chk("t5r_no_done", 64'(done_cnt), 64'd0);
    dout.ready = 1'b1;
    new_job(2, 32'h58, 2, 4'hF);
    wait_done("t5r_done_seen");
    chk_stream("t5r", 2, 32'h58, 4'hF);

    // 6: enable low for four cycles with one beat buffered
    new_job(4, 32'h60, 4, 4'hA);
    cyc();
    chk("t6_acc_pre", 64'(acc_cnt), 64'd1);
    enable = 1'b0;
    repeat (4) cyc();
    chk("t6_acc_win", 64'(acc_cnt), 64'd1);
    chk("t6_drained", 64'(got_q.size()), 64'd1);
    chk("t6_busy_win", 64'(busy), 64'd1);
    chk("t6_no_done_win", 64'(done_cnt), 64'd0);
    enable = 1'b1;
    wait_done("t6_done_seen");
    chk("t6_acc", 64'(acc_cnt), 64'd4);
    chk_stream("t6", 4, 32'h60, 4'hA);
    chk("t6_done_once", 64'(done_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
